// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding load/store, fixed wait latency,
// RISC-V funct3 sizing with sign/zero extension and misalignment errors.
module dmem_responder #(
   parameter int ADDR_WIDTH  = 10,
   parameter int WAIT_CYCLES = 1
) (
   input  logic        clock,
   input  logic        clear,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [2:0]  req_funct3,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);

   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } state_t;

   state_t                  state;
   state_t                  state_next;
   logic [3:0]              count;
   logic [3:0]              count_next;
   logic                    accept;
   logic                    commit;

   logic                    we_q;
   logic [ADDR_WIDTH+1:0]   addr_q;
   logic [31:0]             wdata_q;
   logic [2:0]              funct3_q;

   logic [31:0]             mem [DEPTH];
   logic [ADDR_WIDTH-1:0]   idx;
   logic [1:0]              lane;
   logic [31:0]             word;
   logic [7:0]              bsel;
   logic [15:0]             hsel;
   logic                    err;
   logic [31:0]             load_data;
   logic [3:0]              be;
   logic [31:0]             wlane;
   logic                    wr_en;
   logic                    unused_addr;

   assign unused_addr = ^req_addr[31:ADDR_WIDTH+2];
   assign req_ready   = (state == IDLE);
   assign idx         = addr_q[ADDR_WIDTH+1:2];
   assign lane        = addr_q[1:0];

   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         state <= IDLE;
         count <= '0;
      end else begin
         state <= state_next;
         count <= count_next;
      end
   end

   always_comb begin
      state_next = state;
      count_next = count;
      accept     = 1'b0;
      commit     = 1'b0;
      unique case (state)
         IDLE: begin
            if (req_valid) begin
               accept     = 1'b1;
               count_next = WAIT_INIT;
               if (WAIT_CYCLES == 0) state_next = RESP;
               else state_next = WAIT;
            end
         end
         WAIT: begin
            count_next = count - 4'd1;
            if (count <= 4'd1) state_next = RESP;
         end
         RESP: begin
            commit     = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Size/alignment legality; BU/HU exist only as loads.
   always_comb begin
      case (funct3_q)
         3'b000:  err = 1'b0;
         3'b001:  err = addr_q[0];
         3'b010:  err = |addr_q[1:0];
         3'b100:  err = we_q;
         3'b101:  err = we_q | addr_q[0];
         default: err = 1'b1;
      endcase
   end

   always_comb begin
      word      = mem[idx];
      bsel      = word[{lane, 3'b000} +: 8];
      hsel      = addr_q[1] ? word[31:16] : word[15:0];
      load_data = '0;
      if (!we_q) begin
         case (funct3_q)
            3'b000:  load_data = {{24{bsel[7]}}, bsel};
            3'b100:  load_data = {24'd0, bsel};
            3'b001:  load_data = {{16{hsel[15]}}, hsel};
            3'b101:  load_data = {16'd0, hsel};
            3'b010:  load_data = word;
            default: load_data = '0;
         endcase
      end
   end

   always_comb begin
      case (funct3_q[1:0])
         2'b00: begin
            be    = 4'b0001 << lane;
            wlane = {4{wdata_q[7:0]}};
         end
         2'b01: begin
            be    = addr_q[1] ? 4'b1100 : 4'b0011;
            wlane = {2{wdata_q[15:0]}};
         end
         default: begin
            be    = 4'b1111;
            wlane = wdata_q;
         end
      endcase
   end

   // A clear landing on the commit edge must discard the store.
   assign wr_en = commit & we_q & ~err & ~clear;

   always_ff @(posedge clock) begin
      if (wr_en) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) mem[idx][8*i +: 8] <= wlane[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         funct3_q   <= '0;
         resp_valid <= 1'b0;
         resp_rdata <= '0;
         resp_err   <= 1'b0;
      end else begin
         if (accept) begin
            we_q     <= req_we;
            addr_q   <= req_addr[ADDR_WIDTH+1:0];
            wdata_q  <= req_wdata;
            funct3_q <= req_funct3;
         end
         resp_valid <= commit;
         resp_err   <= commit & err;
         resp_rdata <= (commit && !err) ? load_data : '0;
      end
   end

endmodule
